// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with write-through bypass, optional hardwired r0
// and a per-register pending-write scoreboard (busy bits, busy count, sticky error).
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_ok;
    logic              rsv_ok;
    logic              err_nxt;
    logic              hit1;
    logic              hit2;
    logic              zero1;
    logic              zero2;

    // Writes and reserves aimed at a hardwired r0 are dropped entirely.
    assign wr_ok  = wr_en  & ~(ZERO_REG != 0 && wr_addr  == '0);
    assign rsv_ok = rsv_en & ~(ZERO_REG != 0 && rsv_addr == '0);

    // A writeback that finds no pending reservation (and is not re-reserved this edge) is illegal.
    assign err_nxt = wr_ok & ~busy[wr_addr] & ~(rsv_ok & rsv_addr == wr_addr);

    // Next busy vector and its popcount; a reserve beats a release on the same register.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_ok)
            busy_nxt[rsv_addr] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    // Register array, scoreboard bits, busy count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_data;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            err      <= err | err_nxt;
        end
    end

    // Bypass is suppressed while reset is held so the read ports stay at zero.
    assign hit1  = BYPASS != 0 && wr_en && wr_addr == rd_addr1;
    assign hit2  = BYPASS != 0 && wr_en && wr_addr == rd_addr2;
    assign zero1 = ZERO_REG != 0 && rd_addr1 == '0;
    assign zero2 = ZERO_REG != 0 && rd_addr2 == '0;

    assign rd_data1 = zero1 ? '0 : (hit1 && rst_n) ? wr_data : regs[rd_addr1];
    assign rd_data2 = zero2 ? '0 : (hit2 && rst_n) ? wr_data : regs[rd_addr2];
    assign rd_busy1 = busy[rd_addr1] & ~hit1;
    assign rd_busy2 = busy[rd_addr2] & ~hit2;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: vector table, reset/corner sequences and randomized model check.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0, we = 1'b0;
    logic [4:0]  ra = '0, wa = '0, a1 = '0, a2 = '0;
    logic [31:0] wd = '0;
    logic [31:0] d1, d2;
    logic        b1, b2, err;
    logic [5:0]  cnt;

    logic        s_re = 1'b0, s_we = 1'b0;
    logic [2:0]  s_ra = '0, s_wa = '0, s_a1 = '0, s_a2 = '0;
    logic [15:0] s_wd = '0;
    logic [15:0] s_d1, s_d2;
    logic        s_b1, s_b2, s_err;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_err;

    typedef struct {
        logic        re;
        logic [4:0]  ra;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [31:0] e_d1;
        logic        e_b1;
        logic [5:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl [13];

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(a1), .rd_addr2(a2), .rd_data1(d1), .rd_data2(d2),
        .rd_busy1(b1), .rd_busy2(b2),
        .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .rsv_en(re), .rsv_addr(ra), .busy_cnt(cnt), .err(err)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(s_a1), .rd_addr2(s_a2), .rd_data1(s_d1), .rd_data2(s_d2),
        .rd_busy1(s_b1), .rd_busy2(s_b2),
        .wr_en(s_we), .wr_addr(s_wa), .wr_data(s_wd),
        .rsv_en(s_re), .rsv_addr(s_ra), .busy_cnt(s_cnt), .err(s_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [4:0] rr, input logic w,
                                input logic [4:0] ww, input logic [31:0] dd, input logic [4:0] aa,
                                input logic [31:0] ed, input logic eb, input logic [5:0] ec,
                                input logic ee);
        vec_t v;
        v.re = r; v.ra = rr; v.we = w; v.wa = ww; v.wd = dd; v.a1 = aa;
        v.e_d1 = ed; v.e_b1 = eb; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rr, input logic w, input logic [4:0] ww,
                         input logic [31:0] dd, input logic [4:0] x1, input logic [4:0] x2);
        re = r; ra = rr; we = w; wa = ww; wd = dd; a1 = x1; a2 = x2;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m_reg[a];
    endfunction

    function automatic logic m_bsy(input logic [4:0] a);
        return m_busy[a] && !(we && wa == a);
    endfunction

    function automatic logic [5:0] m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return 6'(n);
    endfunction

    task automatic model_edge();
        if (we && wa != 0) begin
            if (!m_busy[wa] && !(re && ra == wa)) m_err = 1'b1;
            m_reg[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (re && ra != 0) m_busy[ra] = 1'b1;
    endtask

    task automatic step(input logic r, input logic [4:0] rr, input logic w, input logic [4:0] ww,
                        input logic [31:0] dd, input logic [4:0] x1, input logic [4:0] x2);
        drive(r, rr, w, ww, dd, x1, x2);
        #2;
        chk("rd_data1", d1, m_rd(a1));
        chk("rd_data2", d2, m_rd(a2));
        chk("rd_busy1", 32'(b1), 32'(m_bsy(a1)));
        chk("rd_busy2", 32'(b2), 32'(m_bsy(a2)));
        chk("busy_cnt", 32'(cnt), 32'(m_cnt()));
        chk("err", 32'(err), 32'(m_err));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        tbl[0]  = mk(1, 5, 0, 0, 32'h0,        5, 32'h0,        0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        5, 32'h0,        1, 1, 0);
        tbl[2]  = mk(0, 0, 1, 5, 32'hDEADBEEF, 5, 32'hDEADBEEF, 0, 1, 0);
        tbl[3]  = mk(1, 7, 0, 0, 32'h0,        5, 32'hDEADBEEF, 0, 0, 0);
        tbl[4]  = mk(1, 7, 1, 7, 32'h1234,     7, 32'h1234,     0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,        7, 32'h1234,     1, 1, 0);
        tbl[6]  = mk(1, 0, 1, 0, 32'hFFFFFFFF, 0, 32'h0,        0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0);
        tbl[8]  = mk(0, 0, 1, 9, 32'h55,       9, 32'h55,       0, 1, 0);
        tbl[9]  = mk(1, 3, 0, 0, 32'h0,        9, 32'h55,       0, 1, 1);
        tbl[10] = mk(0, 0, 1, 3, 32'hAA,       3, 32'hAA,       0, 2, 1);
        tbl[11] = mk(0, 0, 1, 7, 32'h77,       7, 32'h77,       0, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,        7, 32'h77,       0, 0, 1);

        model_clear();
        #2;
        chk("init_d1", d1, 32'h0);
        chk("init_cnt", 32'(cnt), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            drive(tbl[k].re, tbl[k].ra, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].a1, tbl[k].a1);
            #2;
            chk($sformatf("v%0d_d1", k), d1, tbl[k].e_d1);
            chk($sformatf("v%0d_d2", k), d2, tbl[k].e_d1);
            chk($sformatf("v%0d_b1", k), 32'(b1), 32'(tbl[k].e_b1));
            chk($sformatf("v%0d_cnt", k), 32'(cnt), 32'(tbl[k].e_cnt));
            chk($sformatf("v%0d_err", k), 32'(err), 32'(tbl[k].e_err));
            @(posedge clk);
            #1;
        end

        drive(0, 0, 1, 4, 32'h99, 0, 0);
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 5'(i), 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 4, 1);
        #2;
        chk("pre_rst_cnt", 32'(cnt), 32'd3);
        chk("pre_rst_b2", 32'(b2), 32'd1);
        chk("pre_rst_d1", d1, 32'h99);
        rst_n = 1'b0;
        #1;
        chk("rst_d1", d1, 32'h0);
        chk("rst_b2", 32'(b2), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_b2", 32'(b2), 32'd0);
        chk("post_rst_cnt", 32'(cnt), 32'd0);
        chk("post_rst_d1", d1, 32'h0);
        model_clear();

        for (int i = 0; i < 1500; i++) begin
            if (i == 750) reset_pulse();
            step(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
                 $urandom, 5'($urandom), 5'($urandom));
        end

        reset_pulse();
        for (int i = 1; i <= 31; i++) step(1, 5'(i), 0, 0, 0, 5'(i), 0);
        chk("all_rsv_cnt", 32'(cnt), 32'd31);
        for (int i = 31; i >= 1; i--) begin
            step(0, 0, 1, 5'(i), 32'(i * 3), 5'(i), 5'(i));
            chk($sformatf("drain_cnt_%0d", i), 32'(cnt), 32'(i - 1));
        end
        chk("drain_err", 32'(err), 32'd0);

        for (int i = 1; i <= 7; i++) begin
            s_re = 1'b1; s_ra = 3'(i);
            @(posedge clk); #1;
        end
        s_re = 1'b0;
        chk("s_all_rsv_cnt", 32'(s_cnt), 32'd7);
        for (int i = 7; i >= 1; i--) begin
            s_we = 1'b1; s_wa = 3'(i); s_wd = 16'(i * 16'h111); s_a1 = 3'(i);
            #2;
            chk($sformatf("s_byp_%0d", i), 32'(s_d1), 32'(i * 16'h111));
            chk($sformatf("s_busy_%0d", i), 32'(s_b1), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("s_cnt_%0d", i), 32'(s_cnt), 32'(i - 1));
        end
        s_we = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            s_a1 = 3'(i);
            #1;
            chk($sformatf("s_rd_%0d", i), 32'(s_d1), 32'(i * 16'h111));
        end
        chk("s_err", 32'(s_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
